// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the fetch queue: entry layout, exception bit
// index, reset PC default and drop-counter width.
package if_fetch_queue_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC00000;

  localparam int FQ_PC_W   = 32;
  localparam int FQ_INST_W = 32;
  localparam int FQ_EXC_W  = 1;

  // Exception vector bit carrying an instruction-fetch address error.
  localparam int EXC_ADEL  = 0;

  // Responses still owed by the icache for squashed requests. Redirects
  // can stack, so this is wider than the credit counter.
  localparam int DROP_W    = 8;

  typedef struct packed {
    logic [FQ_PC_W-1:0]   pc;
    logic [FQ_INST_W-1:0] inst;
    logic [FQ_EXC_W-1:0]  exc;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

  function automatic fq_entry_t make_entry(input logic [FQ_PC_W-1:0] pc,
                                           input logic [FQ_INST_W-1:0] inst,
                                           input logic adel);
    fq_entry_t e;
    e.pc            = pc;
    e.inst          = inst;
    e.exc           = '0;
    e.exc[EXC_ADEL] = adel;
    return e;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// Synchronous FIFO with clear, used for the request-PC FIFO and the
// instruction queue. DEPTH must be a power of two (>= 2). A push is taken
// at full when a pop happens in the same cycle; clear wins over both.
module if_fetch_queue_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_eff, pop_eff;

  // Status flags, effective push/pop and next pointer/count values.
  always_comb begin
    full_o   = (count_q == CNT_W'(DEPTH));
    empty_o  = (count_q == '0);
    pop_eff  = pop_i & ~empty_o;
    push_eff = push_i & (~full_o | pop_eff);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_eff && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// IF stage: owns the fetch PC, issues pipelined icache requests under a
// credit limit of FQ_DEPTH, queues returned instructions for ID and
// squashes queued/in-flight fetches on redirect (flush beats branch).
// Build option IFQ_BYPASS_EN: a response arriving at an empty queue is
// presented to ID combinationally in the same cycle.
//
// Handshakes: a transfer occurs on a rising edge where valid and ready are
// both high. valid never depends on ready. req_valid_o may drop without a
// transfer when a redirect arrives; id_* is cleared by a redirect.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        br_en_i,
  input  logic [31:0] br_pc_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_adel_o
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic [31:0]           pc_q, pc_d;
  logic                  halt_q, halt_d;
  logic                  fetch_en_q, fetch_en_d;
  logic [CNT_W-1:0]      outst_q, outst_d;
  logic [DROP_W-1:0]     drop_q, drop_d;

  logic                  redirect;
  logic [31:0]           redirect_pc;
  logic [CNT_W:0]        inflight;
  logic                  req_fire, rsp_drop, rsp_take, rsp_cnt;
  logic                  adel_push, byp_active, byp_consumed;
  logic                  q_push, q_pop, q_full, q_empty;
  logic [CNT_W-1:0]      q_count;
  logic [FQ_ENTRY_W-1:0] q_wdata, q_rdata;
  fq_entry_t             q_head;
  logic [31:0]           pcf_head;
  logic                  pcf_full, pcf_empty;
  logic [CNT_W-1:0]      pcf_count;

  // Fetch control: credits, request issue, response routing, AdEL insertion.
  always_comb begin
    redirect    = flush_i | br_en_i;
    redirect_pc = flush_i ? flush_pc_i : br_pc_i;
    inflight    = {1'b0, q_count} + {1'b0, outst_q};
    req_valid_o = fetch_en_q & ~halt_q & ~redirect &
                  (inflight < (CNT_W+1)'(FQ_DEPTH)) & (pc_q[1:0] == 2'b00);
    req_addr_o  = pc_q;
    req_fire    = req_valid_o & req_ready_i;
    rsp_drop    = rsp_valid_i & (drop_q != '0);
    rsp_take    = rsp_valid_i & (drop_q == '0) & ~pcf_empty & ~redirect;
    // A response retires either one owed drop or one outstanding request.
    rsp_cnt     = rsp_valid_i & ((drop_q != '0) | ~pcf_empty);
    q_pop       = ~q_empty & id_ready_i & ~redirect;
    adel_push   = fetch_en_q & ~halt_q & ~redirect & (pc_q[1:0] != 2'b00) &
                  (outst_q == '0) & (drop_q == '0) & (~q_full | q_pop);
`ifdef IFQ_BYPASS_EN
    byp_active  = q_empty & rsp_take;
`else
    byp_active  = 1'b0;
`endif
    byp_consumed = byp_active & id_ready_i;
    q_push       = (rsp_take & ~byp_consumed) | adel_push;
    q_wdata      = adel_push ? make_entry(pc_q, 32'h0, 1'b1)
                             : make_entry(pcf_head, rsp_inst_i, 1'b0);
  end

  // ID-side view: queue head, or the live response when bypassing.
  always_comb begin
    q_head     = fq_entry_t'(q_rdata);
    id_valid_o = ~q_empty;
    id_pc_o    = q_head.pc;
    id_inst_o  = q_head.inst;
    id_adel_o  = q_head.exc[EXC_ADEL];
    if (byp_active) begin
      id_valid_o = 1'b1;
      id_pc_o    = pcf_head;
      id_inst_o  = rsp_inst_i;
      id_adel_o  = 1'b0;
    end
  end

  // Next-state for PC, halt, outstanding-request and drop counters.
  always_comb begin
    fetch_en_d = 1'b1;
    pc_d       = pc_q;
    halt_d     = halt_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    if (redirect) begin
      pc_d    = redirect_pc;
      halt_d  = 1'b0;
      outst_d = '0;
      drop_d  = drop_q + DROP_W'(outst_q) - DROP_W'(rsp_cnt);
    end else begin
      if (req_fire)  pc_d   = pc_q + 32'd4;
      if (adel_push) halt_d = 1'b1;
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_take);
      drop_d  = drop_q - DROP_W'(rsp_drop);
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      halt_q     <= 1'b0;
      fetch_en_q <= 1'b0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      halt_q     <= halt_d;
      fetch_en_q <= fetch_en_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // PCs of outstanding requests, paired with responses in order.
  if_fetch_queue_fifo #(.WIDTH(32), .DEPTH(FQ_DEPTH)) u_pc_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_take),
    .rdata_o (pcf_head),
    .full_o  (pcf_full),
    .empty_o (pcf_empty),
    .count_o (pcf_count)
  );

  // Instruction queue feeding ID.
  if_fetch_queue_fifo #(.WIDTH(FQ_ENTRY_W), .DEPTH(FQ_DEPTH)) u_inst_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (q_push),
    .wdata_i (q_wdata),
    .pop_i   (q_pop),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

`ifndef SYNTHESIS
  // Protocol and bookkeeping checks for simulation.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(rsp_valid_i && outst_q == '0 && drop_q == '0));
      assert (pcf_count == outst_q);
      assert (!(req_fire && pcf_full));
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with an in-order icache responder,
// a request scoreboard and an ID-side scoreboard.
module tb_if_fetch_queue;

`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic        br_en_i = 1'b0;
  logic [31:0] br_pc_i = '0;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_inst_i = '0;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_adel_o;

  logic [64:0] exp_q[$];      // {pc, inst, adel} expected at ID
  logic [31:0] exp_req_q[$];  // expected request addresses
  logic [31:0] pend_q[$];     // requests the icache still has to answer
  int          fire_cyc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fire_cnt = 0;
  int          cyc = 0;
  logic        rsp_en = 1'b0;
  logic [64:0] e;
  logic        found;

  // Clock and reset-free timeout
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: got time %0t required finish earlier", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  if_fetch_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .br_en_i     (br_en_i),
    .br_pc_i     (br_pc_i),
    .req_valid_o (req_valid_o),
    .req_addr_o  (req_addr_o),
    .req_ready_i (req_ready_i),
    .rsp_valid_i (rsp_valid_i),
    .rsp_inst_i  (rsp_inst_i),
    .id_valid_o  (id_valid_o),
    .id_ready_i  (id_ready_i),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .id_adel_o   (id_adel_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a == 32'h80006000) ? 32'h24020001 : ~a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Issue exactly n requests, then deassert req_ready_i.
  task automatic fetch_n(input int n);
    int base;
    int guard;
    base  = fire_cnt;
    guard = 0;
    req_ready_i = 1'b1;
    while ((fire_cnt - base) < n && guard < 200) begin
      step();
      guard++;
    end
    req_ready_i = 1'b0;
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got %0d fires expected %0d", fire_cnt - base, n);
    end
  endtask

  task automatic one_redirect(input logic fl, input logic [31:0] fpc,
                              input logic br, input logic [31:0] bpc);
    flush_i = fl; flush_pc_i = fpc; br_en_i = br; br_pc_i = bpc;
    step();
    flush_i = 1'b0; br_en_i = 1'b0;
  endtask

  // Icache responder: answers requests in order, one cycle after issue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rsp_valid_i && pend_q.size() > 0) void'(pend_q.pop_front());
      if (rsp_en && pend_q.size() > 0) begin
        rsp_valid_i = 1'b1;
        rsp_inst_i  = inst_of(pend_q[0]);
      end else begin
        rsp_valid_i = 1'b0;
        rsp_inst_i  = '0;
      end
    end
  end

  // Monitor: request scoreboard and ID scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n && req_valid_o && req_ready_i) begin
      fire_cnt++;
      fire_cyc_q.push_back(cyc);
      pend_q.push_back(req_addr_o);
      if (exp_req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got %h expected no request", req_addr_o);
      end else begin
        check("req_addr", {32'h0, req_addr_o}, {32'h0, exp_req_q.pop_front()});
      end
    end
    if (rst_n && id_valid_o && id_ready_i && !flush_i && !br_en_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL id_unexpected: got pc %h expected no ID transfer", id_pc_o);
      end else begin
        e = exp_q.pop_front();
        check("id_pc",   {32'h0, id_pc_o},   {32'h0, e[64:33]});
        check("id_inst", {32'h0, id_inst_o}, {32'h0, e[32:1]});
        check("id_adel", {63'h0, id_adel_o}, {63'h0, e[0]});
      end
    end
  end

  initial begin
    // Reset state
    step(3);
    @(negedge clk);
    check("rst_req_valid", {63'h0, req_valid_o}, 64'h0);
    check("rst_id_valid",  {63'h0, id_valid_o},  64'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Four credits, queue fills with ID stalled
    exp_req_q.push_back(32'hBFC00000); exp_q.push_back({32'hBFC00000, 32'h403FFFFF, 1'b0});
    exp_req_q.push_back(32'hBFC00004); exp_q.push_back({32'hBFC00004, 32'h403FFFFB, 1'b0});
    exp_req_q.push_back(32'hBFC00008); exp_q.push_back({32'hBFC00008, 32'h403FFFF7, 1'b0});
    exp_req_q.push_back(32'hBFC0000C); exp_q.push_back({32'hBFC0000C, 32'h403FFFF3, 1'b0});
    rsp_en = 1'b1; id_ready_i = 1'b0; req_ready_i = 1'b1;
    step(15);
    check("credit_fires",     fire_cnt,             64'd4);
    check("credit_req_valid", {63'h0, req_valid_o}, 64'h0);
    if (fire_cyc_q.size() >= 3) begin
      check("fire_spacing_1", fire_cyc_q[1] - fire_cyc_q[0], 64'd1);
      check("fire_spacing_2", fire_cyc_q[2] - fire_cyc_q[1], 64'd1);
    end
    req_ready_i = 1'b0; id_ready_i = 1'b1;
    step(8);
    check("drain_empty", exp_q.size(), 64'd0);
    check("credit_back", {63'h0, req_valid_o}, 64'h1);

    // Branch with two requests outstanding
    rsp_en = 1'b0;
    exp_req_q.push_back(32'hBFC00010);
    exp_req_q.push_back(32'hBFC00014);
    fetch_n(2);
    br_en_i = 1'b1; br_pc_i = 32'h80001000;
    #1;
    check("redirect_blocks_req", {63'h0, req_valid_o}, 64'h0);
    step();
    br_en_i = 1'b0;
    exp_req_q.push_back(32'h80001000);
    exp_q.push_back({32'h80001000, 32'h7FFFEFFF, 1'b0});
    rsp_en = 1'b1; id_ready_i = 1'b1;
    fetch_n(1);
    step(8);
    check("br_drained", exp_q.size(), 64'd0);
    check("br_pend_done", pend_q.size(), 64'd0);

    // Flush and branch together: flush target wins
    one_redirect(1'b1, 32'hBFC00380, 1'b1, 32'h80002000);
    exp_req_q.push_back(32'hBFC00380);
    exp_q.push_back({32'hBFC00380, 32'h403FFC7F, 1'b0});
    fetch_n(1);
    step(6);
    check("flush_prio_drained", exp_q.size(), 64'd0);

    // Misaligned branch target: AdEL entry, then fetch halts
    exp_q.push_back({32'h80000002, 32'h00000000, 1'b1});
    one_redirect(1'b0, 32'h0, 1'b1, 32'h80000002);
    req_ready_i = 1'b1;
    step(10);
    check("adel_halt_req", {63'h0, req_valid_o}, 64'h0);
    check("adel_drained", exp_q.size(), 64'd0);
    req_ready_i = 1'b0;
    one_redirect(1'b1, 32'hBFC00200, 1'b0, 32'h0);
    exp_req_q.push_back(32'hBFC00200);
    exp_q.push_back({32'hBFC00200, 32'h403FFDFF, 1'b0});
    fetch_n(1);
    step(6);
    check("adel_recover", exp_q.size(), 64'd0);

    // Stacked redirects accumulate owed drops (2 + 1)
    rsp_en = 1'b0;
    exp_req_q.push_back(32'hBFC00204);
    exp_req_q.push_back(32'hBFC00208);
    fetch_n(2);
    one_redirect(1'b0, 32'h0, 1'b1, 32'h80003000);
    exp_req_q.push_back(32'h80003000);
    fetch_n(1);
    one_redirect(1'b0, 32'h0, 1'b1, 32'h80004000);
    rsp_en = 1'b1;
    exp_req_q.push_back(32'h80004000);
    exp_q.push_back({32'h80004000, 32'h7FFFBFFF, 1'b0});
    fetch_n(1);
    step(10);
    check("stack_pend_done", pend_q.size(), 64'd0);
    check("stack_drained", exp_q.size(), 64'd0);

    // Response into an empty queue: bypass timing
    one_redirect(1'b0, 32'h0, 1'b1, 32'h80006000);
    rsp_en = 1'b0;
    exp_req_q.push_back(32'h80006000);
    exp_q.push_back({32'h80006000, 32'h24020001, 1'b0});
    fetch_n(1);
    rsp_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rsp_valid_i) found = 1'b1;
    end
    check("rsp_seen", {63'h0, found}, 64'h1);
    check("rsp_cycle_id_valid", {63'h0, id_valid_o}, {63'h0, BYP});
    @(negedge clk);
    check("after_rsp_id_valid", {63'h0, id_valid_o}, {63'h0, ~BYP});
    step(4);
    check("rsp_drained", exp_q.size(), 64'd0);

    // Asynchronous reset mid-operation
    rsp_en = 1'b0; id_ready_i = 1'b0;
    exp_req_q.push_back(32'h80006004);
    exp_req_q.push_back(32'h80006008);
    fetch_n(2);
    rsp_en = 1'b1;
    step(5);
    check("pre_reset_id_valid", {63'h0, id_valid_o}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_id_valid",  {63'h0, id_valid_o},  64'h0);
    check("async_rst_req_valid", {63'h0, req_valid_o}, 64'h0);
    check("async_rst_pc",        {32'h0, req_addr_o},  64'hBFC00000);
    rsp_en = 1'b0;
    pend_q.delete();
    step(2);
    rst_n = 1'b1;
    exp_req_q.push_back(32'hBFC00000);
    exp_q.push_back({32'hBFC00000, 32'h403FFFFF, 1'b0});
    rsp_en = 1'b1; id_ready_i = 1'b1;
    fetch_n(1);
    step(6);

    check("final_exp_q",     exp_q.size(),     64'd0);
    check("final_exp_req_q", exp_req_q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
